// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: default frame geometry,
// the frame-writer state encoding and the RGB565 -> RGB444 pixel conversion.
package camera_pkg;

    localparam int CAM_WIDTH  = 320;
    localparam int CAM_HEIGHT = 240;

    typedef enum logic {
        SYNC,
        CAPTURE
    } cam_state_t;

    // Keep the top four bits of each colour channel; green drops its extra LSB too.
    function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] pixel);
        return {pixel[15:12], pixel[10:7], pixel[4:1]};
    endfunction

endpackage

// File: rtl/camera_frame_writer.sv
// Camera frame writer: tracks the x/y position of the incoming RGB565 pixel
// stream, converts pixels to RGB444 and writes them into one half of a
// double-buffered BRAM frame store. Only complete, well-formed frames flip the
// buffer and are published to the display side through ready_buffer_out.
// Optional build macro CAMERA_FRAME_WRITER_DECIMATE_EN stores a 2x-decimated
// image (every other pixel of every other row).
module camera_frame_writer
    import camera_pkg::*;
#(
    parameter int WIDTH  = CAM_WIDTH,
    parameter int HEIGHT = CAM_HEIGHT,
    parameter int ADDR_W = 18
) (
    input  logic              pixel_clock_in,
    input  logic              reset_n_in,
    input  logic [15:0]       pixel_data_in,
    input  logic              pixel_valid_in,
    input  logic              frame_done_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [11:0]       bram_data_out,
    output logic              bram_we_out,
    output logic              frame_ready_out,
    output logic              ready_buffer_out,
    output logic              frame_error_out,
    output logic [7:0]        dropped_frames_out
);

`ifdef CAMERA_FRAME_WRITER_DECIMATE_EN
    localparam int STORE_W = WIDTH / 2;
    localparam int STORE_H = HEIGHT / 2;
`else
    localparam int STORE_W = WIDTH;
    localparam int STORE_H = HEIGHT;
`endif

    localparam int X_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int Y_W   = $clog2(HEIGHT + 1);
    localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1) + 1;

    localparam logic [X_W-1:0]    X_LAST       = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_END        = Y_W'(HEIGHT);
    localparam logic [CNT_W-1:0]  FRAME_PIXELS = CNT_W'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0] BUF1_BASE    = ADDR_W'(STORE_W * STORE_H);

    cam_state_t        state;
    logic              wr_buf;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [CNT_W-1:0]  pixel_count;
    logic              overflow;
    logic [ADDR_W-1:0] wr_index;

    logic              in_frame;
    logic              store_pixel;
    logic [CNT_W-1:0]  count_next;
    logic              overflow_next;
    logic              frame_good;
    logic              next_buf;

    // Per-cycle decisions: whether this pixel is stored, and how the frame would be judged if it ended now.
    always_comb begin
        in_frame = (y < Y_END);
`ifdef CAMERA_FRAME_WRITER_DECIMATE_EN
        store_pixel = pixel_valid_in && in_frame && !x[0] && !y[0];
`else
        store_pixel = pixel_valid_in && in_frame;
`endif
        count_next    = pixel_count + CNT_W'(pixel_valid_in);
        overflow_next = overflow | (pixel_valid_in & ~in_frame);
        frame_good    = (count_next == FRAME_PIXELS) && !overflow_next;
        next_buf      = frame_good ? ~wr_buf : wr_buf;
    end

    // Frame FSM, position counters, running write address and all registered outputs.
    always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state              <= SYNC;
            wr_buf             <= 1'b0;
            x                  <= '0;
            y                  <= '0;
            pixel_count        <= '0;
            overflow           <= 1'b0;
            wr_index           <= '0;
            bram_addr_out      <= '0;
            bram_data_out      <= '0;
            bram_we_out        <= 1'b0;
            frame_ready_out    <= 1'b0;
            ready_buffer_out   <= 1'b0;
            frame_error_out    <= 1'b0;
            dropped_frames_out <= '0;
        end else begin
            bram_we_out     <= 1'b0;
            frame_ready_out <= 1'b0;
            frame_error_out <= 1'b0;
            case (state)
                SYNC: begin
                    if (frame_done_in) begin
                        state       <= CAPTURE;
                        x           <= '0;
                        y           <= '0;
                        pixel_count <= '0;
                        overflow    <= 1'b0;
                        wr_index    <= wr_buf ? BUF1_BASE : '0;
                    end
                end
                CAPTURE: begin
                    if (pixel_valid_in) begin
                        pixel_count <= count_next;
                        overflow    <= overflow_next;
                        if (in_frame) begin
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + Y_W'(1);
                            end else begin
                                x <= x + X_W'(1);
                            end
                        end
                    end
                    if (store_pixel) begin
                        bram_we_out   <= 1'b1;
                        bram_addr_out <= wr_index;
                        bram_data_out <= rgb565_to_rgb444(pixel_data_in);
                        wr_index      <= wr_index + ADDR_W'(1);
                    end
                    if (frame_done_in) begin
                        if (frame_good) begin
                            frame_ready_out  <= 1'b1;
                            ready_buffer_out <= wr_buf;
                        end else begin
                            frame_error_out <= 1'b1;
                            if (dropped_frames_out != 8'hFF) begin
                                dropped_frames_out <= dropped_frames_out + 8'd1;
                            end
                        end
                        wr_buf      <= next_buf;
                        x           <= '0;
                        y           <= '0;
                        pixel_count <= '0;
                        overflow    <= 1'b0;
                        wr_index    <= next_buf ? BUF1_BASE : '0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed self-checking bench for camera_frame_writer with a 4x2 frame.
// A negedge monitor records every BRAM write and every ready/error pulse;
// the initial block drives directed frames and compares against hand-worked values.
module tb_camera_frame_writer;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 18;

    logic              pixel_clock_in = 1'b0;
    logic              reset_n_in;
    logic [15:0]       pixel_data_in;
    logic              pixel_valid_in;
    logic              frame_done_in;
    logic [ADDR_W-1:0] bram_addr_out;
    logic [11:0]       bram_data_out;
    logic              bram_we_out;
    logic              frame_ready_out;
    logic              ready_buffer_out;
    logic              frame_error_out;
    logic [7:0]        dropped_frames_out;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] addr_q[$];
    logic [11:0]       data_q[$];
    int                ready_cnt = 0;
    int                error_cnt = 0;
    logic              last_ready_buf = 1'b0;

    camera_frame_writer #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W)
    ) dut (
        .pixel_clock_in    (pixel_clock_in),
        .reset_n_in        (reset_n_in),
        .pixel_data_in     (pixel_data_in),
        .pixel_valid_in    (pixel_valid_in),
        .frame_done_in     (frame_done_in),
        .bram_addr_out     (bram_addr_out),
        .bram_data_out     (bram_data_out),
        .bram_we_out       (bram_we_out),
        .frame_ready_out   (frame_ready_out),
        .ready_buffer_out  (ready_buffer_out),
        .frame_error_out   (frame_error_out),
        .dropped_frames_out(dropped_frames_out)
    );

    // Free-running pixel clock.
    always #5 pixel_clock_in = ~pixel_clock_in;

    // Monitor on the inactive edge: log writes and count published pulses.
    always @(negedge pixel_clock_in) begin
        if (bram_we_out) begin
            addr_q.push_back(bram_addr_out);
            data_q.push_back(bram_data_out);
        end
        if (frame_ready_out) begin
            ready_cnt++;
            last_ready_buf = ready_buffer_out;
        end
        if (frame_error_out) begin
            error_cnt++;
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic done);
        @(negedge pixel_clock_in);
        pixel_valid_in = valid;
        pixel_data_in  = data;
        frame_done_in  = done;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    endtask

    // Pixels with a one-cycle gap after each; data counts up from base.
    task automatic sendPixels(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, base + 16'(i), 1'b0);
            applyStimulus(1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic endFrame();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        idle(2);
    endtask

    task automatic clearLog();
        addr_q.delete();
        data_q.delete();
    endtask

    function automatic logic [31:0] addrAt(input int i);
        return (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] dataAt(input int i);
        return (i < data_q.size()) ? 32'(data_q[i]) : 32'hFFFF_FFFF;
    endfunction

    logic [11:0] ramp_data [8] = '{12'h000, 12'h000, 12'h001, 12'h001,
                                   12'h002, 12'h002, 12'h003, 12'h003};

    initial begin
        reset_n_in     = 1'b0;
        pixel_valid_in = 1'b0;
        pixel_data_in  = 16'h0000;
        frame_done_in  = 1'b0;
        idle(2);
        checkOutput("reset_we",      32'(bram_we_out),        32'h0);
        checkOutput("reset_addr",    32'(bram_addr_out),      32'h0);
        checkOutput("reset_data",    32'(bram_data_out),      32'h0);
        checkOutput("reset_ready",   32'(frame_ready_out),    32'h0);
        checkOutput("reset_rbuf",    32'(ready_buffer_out),   32'h0);
        checkOutput("reset_err",     32'(frame_error_out),    32'h0);
        checkOutput("reset_dropped", 32'(dropped_frames_out), 32'h0);
        reset_n_in = 1'b1;
        idle(2);

        // Pixels before the first frame boundary are ignored.
        sendPixels(3, 16'h0001);
        idle(2);
        checkOutput("presync_writes", 32'(addr_q.size()), 32'd0);
        endFrame();

`ifdef CAMERA_FRAME_WRITER_DECIMATE_EN
        // Only x=0 and x=2 of row 0 are stored.
        clearLog();
        sendPixels(8, 16'h0010);
        endFrame();
        checkOutput("dec_count",  32'(addr_q.size()), 32'd2);
        checkOutput("dec_addr0",  addrAt(0), 32'd0);
        checkOutput("dec_addr1",  addrAt(1), 32'd1);
        checkOutput("dec_data0",  dataAt(0), 32'h008);
        checkOutput("dec_data1",  dataAt(1), 32'h009);
        checkOutput("dec_ready",  32'(ready_cnt), 32'd1);
        checkOutput("dec_rbuf",   32'(last_ready_buf), 32'd0);
        clearLog();
        sendPixels(8, 16'h0010);
        endFrame();
        checkOutput("dec_buf1_addr0", addrAt(0), 32'd2);
        checkOutput("dec_buf1_addr1", addrAt(1), 32'd3);
        checkOutput("dec_ready2",     32'(ready_cnt), 32'd2);
`else
        // Good frame into buffer 0.
        clearLog();
        sendPixels(8, 16'h0000);
        endFrame();
        checkOutput("f1_count", 32'(addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("f1_addr%0d", i), addrAt(i), 32'(i));
            checkOutput($sformatf("f1_data%0d", i), dataAt(i), 32'(ramp_data[i]));
        end
        checkOutput("f1_ready", 32'(ready_cnt), 32'd1);
        checkOutput("f1_rbuf",  32'(last_ready_buf), 32'd0);
        checkOutput("f1_err",   32'(error_cnt), 32'd0);

        // Good frame into buffer 1, first pixel full magenta.
        clearLog();
        applyStimulus(1'b1, 16'hF81F, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        sendPixels(7, 16'h0000);
        endFrame();
        checkOutput("f2_count", 32'(addr_q.size()), 32'd8);
        checkOutput("f2_addr0", addrAt(0), 32'd8);
        checkOutput("f2_addr7", addrAt(7), 32'd15);
        checkOutput("f2_magenta", dataAt(0), 32'h0F0F);
        checkOutput("f2_ready", 32'(ready_cnt), 32'd2);
        checkOutput("f2_rbuf",  32'(ready_buffer_out), 32'd1);

        // Short frame in buffer 0, then the same buffer is reused.
        clearLog();
        sendPixels(6, 16'h0000);
        endFrame();
        checkOutput("short_count",   32'(addr_q.size()), 32'd6);
        checkOutput("short_addr0",   addrAt(0), 32'd0);
        checkOutput("short_err",     32'(error_cnt), 32'd1);
        checkOutput("short_dropped", 32'(dropped_frames_out), 32'd1);
        checkOutput("short_noready", 32'(ready_cnt), 32'd2);
        checkOutput("short_rbuf",    32'(ready_buffer_out), 32'd1);
        clearLog();
        sendPixels(8, 16'h0000);
        endFrame();
        checkOutput("reuse_addr0", addrAt(0), 32'd0);
        checkOutput("reuse_addr7", addrAt(7), 32'd15 - 32'd8);
        checkOutput("reuse_ready", 32'(ready_cnt), 32'd3);
        checkOutput("reuse_rbuf",  32'(ready_buffer_out), 32'd0);

        // Long frame in buffer 1: writes stop after 8 pixels.
        clearLog();
        sendPixels(10, 16'h0000);
        endFrame();
        checkOutput("long_count",   32'(addr_q.size()), 32'd8);
        checkOutput("long_addr0",   addrAt(0), 32'd8);
        checkOutput("long_addr7",   addrAt(7), 32'd15);
        checkOutput("long_err",     32'(error_cnt), 32'd2);
        checkOutput("long_dropped", 32'(dropped_frames_out), 32'd2);
        checkOutput("long_noready", 32'(ready_cnt), 32'd3);

        // Last pixel arrives together with the frame boundary.
        clearLog();
        sendPixels(7, 16'h0000);
        applyStimulus(1'b1, 16'h0007, 1'b1);
        idle(2);
        checkOutput("same_count", 32'(addr_q.size()), 32'd8);
        checkOutput("same_addr7", addrAt(7), 32'd15);
        checkOutput("same_data7", dataAt(7), 32'h003);
        checkOutput("same_ready", 32'(ready_cnt), 32'd4);
        checkOutput("same_rbuf",  32'(ready_buffer_out), 32'd1);
        checkOutput("same_err",   32'(error_cnt), 32'd2);

        // Reset in the middle of a frame, away from any clock edge.
        clearLog();
        sendPixels(2, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        #3;
        reset_n_in = 1'b0;
        #1;
        checkOutput("midrst_we",      32'(bram_we_out),        32'h0);
        checkOutput("midrst_addr",    32'(bram_addr_out),      32'h0);
        checkOutput("midrst_rbuf",    32'(ready_buffer_out),   32'h0);
        checkOutput("midrst_dropped", 32'(dropped_frames_out), 32'h0);
        idle(3);
        reset_n_in = 1'b1;
        idle(3);
        checkOutput("midrst_ready", 32'(ready_cnt), 32'd4);
        checkOutput("midrst_err",   32'(error_cnt), 32'd2);

        // Back in SYNC: stray pixels ignored, then buffer 0 restarts at 0.
        clearLog();
        sendPixels(3, 16'h0000);
        idle(1);
        checkOutput("resync_nowrite", 32'(addr_q.size()), 32'd0);
        endFrame();
        sendPixels(8, 16'h0000);
        endFrame();
        checkOutput("resync_addr0", addrAt(0), 32'd0);
        checkOutput("resync_ready", 32'(ready_cnt), 32'd5);
        checkOutput("resync_rbuf",  32'(last_ready_buf), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_frame_writer.md
Name: camera_frame_writer

Overview:
- Consumes the 16-bit RGB565 pixel stream from the camera capture stage (pixel data, pixel valid, frame-done pulse) in the camera pixel clock domain.
- Tracks x/y position, converts each pixel to RGB444, and writes it into a double-buffered dual-port BRAM frame store.
- Publishes which buffer holds the last complete, well-formed frame for the display-side reader.

Parameters:
- WIDTH, 320, active pixels per row delivered by the capture stage.
- HEIGHT, 240, rows per frame.
- ADDR_W, 18, BRAM address width; must hold 2*WIDTH*HEIGHT (2*STORE_W*STORE_H under DECIMATE_EN).

Ports:
- pixel_clock_in  input  1  camera pixel clock; sole clock.
- reset_n_in  input  1  asynchronous, active-low reset.
- pixel_data_in  input  16  RGB565 pixel, {R[15:11], G[10:5], B[4:0]}.
- pixel_valid_in  input  1  pixel_data_in valid this cycle.
- frame_done_in  input  1  one-cycle end-of-frame pulse.
- bram_addr_out  output  ADDR_W  write address.
- bram_data_out  output  12  RGB444 write data, {R4, G4, B4}.
- bram_we_out  output  1  write enable, one cycle per stored pixel.
- frame_ready_out  output  1  one-cycle pulse: a complete frame was committed.
- ready_buffer_out  output  1  index (0/1) of the buffer holding the newest complete frame.
- frame_error_out  output  1  one-cycle pulse: the frame just ended was short or long.
- dropped_frames_out  output  8  saturating count of errored frames.

Behaviour:
- Reset, asserted asynchronously:
  - All outputs 0.
  - State SYNC; write buffer 0; x, y and pixel count 0.
- SYNC state:
  - pixel_valid_in is ignored.
  - On frame_done_in, go to CAPTURE with counters at 0. No ready or error pulse is issued.
- CAPTURE state, on pixel_valid_in:
  - Pixel count increments.
  - If y < HEIGHT, a write is issued with 1-cycle latency (registered):
    - bram_we_out = 1.
    - bram_addr_out = buf*WIDTH*HEIGHT + y*WIDTH + x.
    - bram_data_out = {d[15:12], d[10:7], d[4:1]}.
  - The address comes from a running index register incremented per stored pixel, with the base reloaded at frame start. No multiplier.
  - x wraps from WIDTH-1 to 0 and increments y.
  - Once y == HEIGHT, further pixels produce no write, and an overflow flag is set.
- CAPTURE state, on frame_done_in:
  - Good frame (count == WIDTH*HEIGHT and no overflow):
    - Next cycle: frame_ready_out = 1 and ready_buffer_out = buf.
    - buf toggles.
  - Bad frame:
    - frame_error_out pulses for 1 cycle.
    - dropped_frames_out increments, saturating at 255.
    - buf is not toggled; the next frame overwrites the same buffer.
  - In both cases, counters and flags clear and the state stays CAPTURE.
- pixel_valid_in and frame_done_in asserted in the same cycle:
  - The pixel belongs to the ending frame: it is written and counted before the frame is evaluated.
- frame_ready_out and frame_error_out are mutually exclusive.
- ready_buffer_out changes only on a frame_ready_out pulse. It never points at the buffer currently being written.
- Reset mid-frame: the partial frame is discarded, the block returns to SYNC, and no pulse is issued.

Optional Feature:
- Macro: CAMERA_FRAME_WRITER_DECIMATE_EN.
- Defined:
  - 2x decimation: a write is issued only when x[0]==0 and y[0]==0.
  - Stored image is STORE_W x STORE_H = WIDTH/2 x HEIGHT/2.
  - Buffer base is buf*STORE_W*STORE_H.
  - The completeness check still counts all WIDTH*HEIGHT input pixels.
- Undefined: full-resolution behaviour as above; STORE_W/STORE_H equal WIDTH/HEIGHT.

Decomposition:
- Shared package camera_pkg:
  - Constants CAM_WIDTH and CAM_HEIGHT.
  - State enum typedef {SYNC, CAPTURE}.
  - Function rgb565_to_rgb444.
- No sub-module. Counters and the address generator stay in one always_ff block, with conversion via the package function.

Test Plan (all scenarios use WIDTH=4, HEIGHT=2):
- Reset, then pixels before the first frame_done_in -> bram_we_out stays 0.
- After sync, 8 valid pixels 0x0000..0x0007 with gaps between them, then frame_done_in:
  - Writes go to addr 0..7.
  - frame_ready_out pulses once with ready_buffer_out=0.
  - The next frame writes addr 8..15.
- Pixel 0xF81F -> bram_data_out = 0xF0F.
- Short frame of 6 pixels, then frame_done_in:
  - frame_error_out pulses; dropped_frames_out = 1.
  - The next frame reuses the same base address.
- 10-pixel frame -> only 8 writes occur, then frame_error_out pulses.
- pixel_valid_in with frame_done_in on the 8th pixel -> 8 writes, then frame_ready_out.
- Reset asserted mid-frame -> outputs go to 0 immediately; no pulse follows.
- With DECIMATE_EN and an 8-pixel frame -> writes occur only for input pixels 0 and 2 (x=0 and x=2 of row 0), at addr 0 and 1.
